// File: rtl/counter_frame_tx.sv
// Snapshots the four sequencer counters and streams them as a 6-byte frame
// (header, c1..c4, 8-bit checksum) on a byte-wide valid/ready interface.
module counter_frame_tx #(
  parameter logic [7:0] HDR         = 8'hA5,
  parameter int         SNAP_PERIOD = 0,
  parameter int         PER_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] c1,
  input  logic [7:0] c2,
  input  logic [7:0] c3,
  input  logic [7:0] c4,
  input  logic       snap_req,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic [7:0] dropped
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_B1, ST_B2, ST_B3, ST_B4, ST_CSUM
  } state_t;

  state_t     state;
  logic [7:0] s1, s2, s3, s4, csum;
  logic [7:0] sum_c;
  logic       tick, trig, accept;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Free-running period timer; tick marks the SNAP_PERIOD-1 -> 0 wrap.
  generate
    if (SNAP_PERIOD > 0) begin : g_timer
      logic [PER_W-1:0] timer;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          timer <= '0;
        else if (timer == PER_W'(SNAP_PERIOD - 1))
          timer <= '0;
        else
          timer <= timer + PER_W'(1);
      end
      assign tick = (timer == PER_W'(SNAP_PERIOD - 1));
    end else begin : g_no_timer
      assign tick = 1'b0;
    end
  endgenerate

  assign sum_c  = c1 + c2 + c3 + c4;
  assign trig   = snap_req | tick;
  assign accept = out_valid & out_ready;
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 8'h00;
      dropped   <= 8'h00;
      s1        <= 8'h00;
      s2        <= 8'h00;
      s3        <= 8'h00;
      s4        <= 8'h00;
      csum      <= 8'h00;
    end else begin
      if (trig && state != ST_IDLE)
        dropped <= sat_inc(dropped);
      case (state)
        ST_IDLE: if (trig) begin
          s1        <= c1;
          s2        <= c2;
          s3        <= c3;
          s4        <= c4;
          csum      <= sum_c;
          out_data  <= HDR;
          out_valid <= 1'b1;
          state     <= ST_HDR;
        end
        ST_HDR: if (accept) begin
          out_data <= s1;
          state    <= ST_B1;
        end
        ST_B1: if (accept) begin
          out_data <= s2;
          state    <= ST_B2;
        end
        ST_B2: if (accept) begin
          out_data <= s3;
          state    <= ST_B3;
        end
        ST_B3: if (accept) begin
          out_data <= s4;
          state    <= ST_B4;
        end
        ST_B4: if (accept) begin
          out_data <= csum;
          out_last <= 1'b1;
          state    <= ST_CSUM;
        end
        ST_CSUM: if (accept) begin
          out_data  <= 8'h00;
          out_last  <= 1'b0;
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_frame_tx.sv
// Bench for counter_frame_tx: a request-driven instance and a periodic
// (SNAP_PERIOD=20) instance, both compared against a queue-based frame model.
module tb_counter_frame_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] c1, c2, c3, c4;
  logic       snap_req, out_ready;
  logic [7:0] out_data, dropped;
  logic       out_valid, out_last, busy;
  logic       snap_req_p, out_ready_p;
  logic [7:0] out_data_p, dropped_p;
  logic       out_valid_p, out_last_p, busy_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_frame_tx #(.HDR(8'hA5), .SNAP_PERIOD(0), .PER_W(16)) dut (
    .clk(clk), .reset(reset), .c1(c1), .c2(c2), .c3(c3), .c4(c4),
    .snap_req(snap_req), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .dropped(dropped)
  );

  counter_frame_tx #(.HDR(8'hA5), .SNAP_PERIOD(20), .PER_W(16)) dut_p (
    .clk(clk), .reset(reset), .c1(c1), .c2(c2), .c3(c3), .c4(c4),
    .snap_req(snap_req_p), .out_data(out_data_p), .out_valid(out_valid_p),
    .out_ready(out_ready_p), .out_last(out_last_p), .busy(busy_p),
    .dropped(dropped_p)
  );

  // Reference model: a frame is the list of bytes still to be sent.
  logic [7:0] mq[$];
  logic [7:0] pq[$];
  logic [7:0] m_drop, p_drop;
  int         pk;

  function automatic logic [7:0] frame_sum(input logic [7:0] a, b, c, d);
    int s;
    s = int'(a) + int'(b) + int'(c) + int'(d);
    return 8'(s % 256);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      pq.delete();
      m_drop = 8'h00;
      p_drop = 8'h00;
      pk     = 0;
    end else begin
      bit tk, tr;
      if (mq.size() == 0) begin
        if (snap_req)
          mq = '{8'hA5, c1, c2, c3, c4, frame_sum(c1, c2, c3, c4)};
      end else begin
        if (snap_req && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        if (out_ready) void'(mq.pop_front());
      end
      tk = (pk % 20 == 19);
      pk++;
      tr = snap_req_p || tk;
      if (pq.size() == 0) begin
        if (tr)
          pq = '{8'hA5, c1, c2, c3, c4, frame_sum(c1, c2, c3, c4)};
      end else begin
        if (tr && p_drop != 8'hFF) p_drop = p_drop + 8'd1;
        if (out_ready_p) void'(pq.pop_front());
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00 ||
        busy !== 1'b0 || dropped !== 8'h00) begin
      errors++;
      $display("FAIL reset valid=%b last=%b data=%h busy=%b dropped=%h required all zero",
               out_valid, out_last, out_data, busy, dropped);
    end
    checks++;
    if (out_valid_p !== 1'b0 || out_last_p !== 1'b0 || out_data_p !== 8'h00 ||
        busy_p !== 1'b0 || dropped_p !== 8'h00) begin
      errors++;
      $display("FAIL reset_p valid=%b last=%b data=%h busy=%b dropped=%h required all zero",
               out_valid_p, out_last_p, out_data_p, busy_p, dropped_p);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp_b[6] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    c1 = 8'h01; c2 = 8'h02; c3 = 8'h03; c4 = 8'h04;
    out_ready = 1'b1;
    snap_req  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      snap_req = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_b[i] || out_last !== (i == 5)) begin
        errors++;
        $display("FAIL basic_byte%0d valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                 i, out_valid, out_data, out_last, exp_b[i], (i == 5));
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle busy=%b valid=%b required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_checksum();
    logic [7:0] cv[2][4] = '{'{8'hFF, 8'hFF, 8'hFF, 8'hFF}, '{8'h80, 8'h80, 8'h00, 8'h00}};
    logic [7:0] ck[2]    = '{8'hFC, 8'h00};
    for (int t = 0; t < 2; t++) begin
      c1 = cv[t][0]; c2 = cv[t][1]; c3 = cv[t][2]; c4 = cv[t][3];
      out_ready = 1'b1;
      snap_req  = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        snap_req = 1'b0;
      end
      checks++;
      if (out_valid !== 1'b1 || out_last !== 1'b1 || out_data !== ck[t]) begin
        errors++;
        $display("FAIL checksum%0d valid=%b last=%b data=%h required valid=1 last=1 data=%h",
                 t, out_valid, out_last, out_data, ck[t]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_f[6];
    logic [7:0] got[$];
    logic [7:0] prev_d;
    logic       prev_l, stalled, r, ev, el;
    logic [7:0] ed;
    int         n;
    c1 = 8'($urandom); c2 = 8'($urandom); c3 = 8'($urandom); c4 = 8'($urandom);
    exp_f = '{8'hA5, c1, c2, c3, c4, frame_sum(c1, c2, c3, c4)};
    snap_req  = 1'b1;
    out_ready = 1'b0;
    stalled   = 1'b0;
    prev_d    = 8'h00;
    prev_l    = 1'b0;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      snap_req = 1'b0;
      n++;
      ev = (mq.size() != 0);
      ed = ev ? mq[0] : 8'h00;
      el = (mq.size() == 1);
      checks++;
      if (out_valid !== ev || busy !== ev ||
          (ev && (out_data !== ed || out_last !== el))) begin
        errors++;
        $display("FAIL bp_model valid=%b data=%h last=%b required valid=%b data=%h last=%b",
                 out_valid, out_data, out_last, ev, ed, el);
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l) begin
          errors++;
          $display("FAIL bp_hold valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                   out_valid, out_data, out_last, prev_d, prev_l);
        end
      end
      if (got.size() == 6 && !out_valid) break;
      r = ($urandom_range(0, 99) < 45);
      out_ready = r;
      if (out_valid && r) got.push_back(out_data);
      stalled = out_valid && !r;
      prev_d  = out_data;
      prev_l  = out_last;
      c1 = 8'($urandom); c2 = 8'($urandom); c3 = 8'($urandom); c4 = 8'($urandom);
    end
    checks++;
    if (got.size() != 6) begin
      errors++;
      $display("FAIL bp_accepts got=%0d required=6", got.size());
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_f[i]) begin
        errors++;
        $display("FAIL bp_byte%0d got=%h required=%h", i, got[i], exp_f[i]);
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_drops();
    logic       ev, el;
    logic [7:0] ed;
    c1 = 8'h10; c2 = 8'h20; c3 = 8'h30; c4 = 8'h40;
    out_ready = 1'b0;
    snap_req  = 1'b1;
    @(negedge clk);
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    checks++;
    if (dropped !== 8'h01 || out_valid !== 1'b1 || out_data !== 8'hA5) begin
      errors++;
      $display("FAIL drop_one dropped=%h valid=%b data=%h required 01 1 a5",
               dropped, out_valid, out_data);
    end
    snap_req = 1'b1;
    repeat (300) @(negedge clk);
    snap_req = 1'b0;
    checks++;
    if (dropped !== 8'hFF) begin
      errors++;
      $display("FAIL drop_sat dropped=%h required=ff", dropped);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ev = (mq.size() != 0);
      ed = ev ? mq[0] : 8'h00;
      el = (mq.size() == 1);
      checks++;
      if (out_valid !== ev || dropped !== m_drop ||
          (ev && (out_data !== ed || out_last !== el))) begin
        errors++;
        $display("FAIL drop_frame valid=%b data=%h last=%b dropped=%h required valid=%b data=%h last=%b dropped=%h",
                 out_valid, out_data, out_last, dropped, ev, ed, el, m_drop);
      end
    end
    checks++;
    if (out_valid !== 1'b0 || dropped !== 8'hFF) begin
      errors++;
      $display("FAIL drop_end valid=%b dropped=%h required 0 ff", out_valid, dropped);
    end
  endtask

  task automatic test_periodic();
    int         rises[$];
    logic       prev_v, ev, el;
    logic [7:0] ed;
    int         n;
    out_ready_p = 1'b1;
    snap_req_p  = 1'b0;
    prev_v = out_valid_p;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      c1 = 8'($urandom); c2 = 8'($urandom); c3 = 8'($urandom); c4 = 8'($urandom);
      ev = (pq.size() != 0);
      ed = ev ? pq[0] : 8'h00;
      el = (pq.size() == 1);
      checks++;
      if (out_valid_p !== ev || busy_p !== ev || dropped_p !== p_drop ||
          (ev && (out_data_p !== ed || out_last_p !== el))) begin
        errors++;
        $display("FAIL per_model valid=%b data=%h last=%b dropped=%h required valid=%b data=%h last=%b dropped=%h",
                 out_valid_p, out_data_p, out_last_p, dropped_p, ev, ed, el, p_drop);
      end
      if (out_valid_p && !prev_v) rises.push_back(cyc);
      prev_v = out_valid_p;
    end
    checks++;
    if (rises.size() < 4) begin
      errors++;
      $display("FAIL per_count frames=%0d required>=4", rises.size());
    end
    for (int i = 1; i < rises.size(); i++) begin
      checks++;
      if (rises[i] - rises[i-1] != 20) begin
        errors++;
        $display("FAIL per_spacing gap=%0d required=20", rises[i] - rises[i-1]);
      end
    end
    n = 0;
    while (pk % 20 != 19 && n < 40) begin
      @(negedge clk);
      n++;
    end
    snap_req_p = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      snap_req_p = 1'b0;
      checks++;
      if (out_valid_p !== 1'b1 || dropped_p !== 8'h00 || (i == 0 && out_data_p !== 8'hA5)) begin
        errors++;
        $display("FAIL per_coincident%0d valid=%b data=%h dropped=%h required valid=1 dropped=00",
                 i, out_valid_p, out_data_p, dropped_p);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid_p !== 1'b0 || dropped_p !== 8'h00) begin
      errors++;
      $display("FAIL per_single valid=%b dropped=%h required 0 00", out_valid_p, dropped_p);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] exp_r[6] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    c1 = 8'h55; c2 = 8'h66; c3 = 8'h77; c4 = 8'h88;
    out_ready = 1'b1;
    snap_req  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      snap_req = 1'b0;
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h66) begin
      errors++;
      $display("FAIL rst_b2 valid=%b data=%h required 1 66", out_valid, out_data);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || dropped !== 8'h00 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL rst_async valid=%b busy=%b dropped=%h last=%b required 0 0 00 0",
               out_valid, busy, dropped, out_last);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || dropped !== 8'h00) begin
      errors++;
      $display("FAIL rst_idle valid=%b busy=%b dropped=%h required 0 0 00",
               out_valid, busy, dropped);
    end
    c1 = 8'h11; c2 = 8'h22; c3 = 8'h33; c4 = 8'h44;
    out_ready = 1'b1;
    snap_req  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      snap_req = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_r[i] || out_last !== (i == 5)) begin
        errors++;
        $display("FAIL rst_frame%0d valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                 i, out_valid, out_data, out_last, exp_r[i], (i == 5));
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_frame_end valid=%b required 0", out_valid);
    end
  endtask

  initial begin
    reset       = 1'b1;
    c1 = 8'h00; c2 = 8'h00; c3 = 8'h00; c4 = 8'h00;
    snap_req    = 1'b0;
    out_ready   = 1'b0;
    snap_req_p  = 1'b0;
    out_ready_p = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_checksum();
    test_backpressure();
    test_drops();
    test_periodic();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
